// File: rtl/clk_div_monitor.sv
// Receive-side health checker for an odd-ratio divided clock, sampled as data in clk_in.
// Latency: rise seen 2-3 clk_in after the clk_div edge, measurement registered one cycle later.
// No backpressure: meas_valid/err are fire-and-forget single-cycle pulses, locked is a level.
module clk_div_monitor #(
    parameter int CNT_W   = 8,
    parameter int EXP_DIV = 7,
    parameter int LOCK_N  = 4
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clk_div,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_cnt,
    output logic             meas_valid,
    output logic             err,
    output logic             locked
);

    localparam logic [CNT_W-1:0] EXP_PER   = CNT_W'(EXP_DIV);
    localparam logic [CNT_W-1:0] EXP_HI_LO = CNT_W'(EXP_DIV / 2);
    localparam logic [CNT_W-1:0] EXP_HI_HI = CNT_W'(EXP_DIV / 2 + 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [3:0]       LOCK_CNT  = 4'(LOCK_N);

    typedef enum logic {
        IDLE = 1'b0,
        MEAS = 1'b1
    } state_t;

    state_t           state_q;
    logic             s1_q;
    logic             s2_q;
    logic             s3_q;
    logic [CNT_W-1:0] cnt_per_q;
    logic [CNT_W-1:0] cnt_hi_q;
    logic [3:0]       match_cnt_q;
    logic [3:0]       match_cnt_d;
    logic             rise;
    logic             is_match;

    // Three-flop capture of clk_div; s3 only serves as the previous value for edge detection.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= clk_div;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    // Rising edge of the synchronized clock, and whether the period being closed is good.
    always_comb begin
        rise        = s2_q & ~s3_q;
        is_match    = (cnt_per_q == EXP_PER) &&
                      ((cnt_hi_q == EXP_HI_LO) || (cnt_hi_q == EXP_HI_HI));
        match_cnt_d = match_cnt_q;
        if (match_cnt_q < LOCK_CNT) begin
            match_cnt_d = match_cnt_q + 4'd1;
        end
    end

    // Measurement FSM: counts between rises, publishes results, tracks lock and timeout.
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_per_q   <= '0;
            cnt_hi_q    <= '0;
            match_cnt_q <= '0;
            period      <= '0;
            high_cnt    <= '0;
            meas_valid  <= 1'b0;
            err         <= 1'b0;
            locked      <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            err        <= 1'b0;
            case (state_q)
                IDLE: begin
                    // First rise only opens a window; there is nothing to report yet.
                    if (rise) begin
                        cnt_per_q <= CNT_ONE;
                        cnt_hi_q  <= CNT_ONE;
                        state_q   <= MEAS;
                    end
                end
                MEAS: begin
                    if (rise) begin
                        period     <= cnt_per_q;
                        high_cnt   <= cnt_hi_q;
                        meas_valid <= 1'b1;
                        cnt_per_q  <= CNT_ONE;
                        cnt_hi_q   <= CNT_ONE;
                        if (is_match) begin
                            match_cnt_q <= match_cnt_d;
                            locked      <= (match_cnt_d == LOCK_CNT);
                        end else begin
                            match_cnt_q <= '0;
                            locked      <= 1'b0;
                            err         <= 1'b1;
                        end
                    end else if (cnt_per_q == CNT_MAX) begin
                        // Clock stopped (either level): give up on this window before the counter wraps.
                        err         <= 1'b1;
                        locked      <= 1'b0;
                        match_cnt_q <= '0;
                        cnt_per_q   <= '0;
                        cnt_hi_q    <= '0;
                        state_q     <= IDLE;
                    end else begin
                        cnt_per_q <= cnt_per_q + CNT_ONE;
                        if (s2_q) begin
                            cnt_hi_q <= cnt_hi_q + CNT_ONE;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_monitor.sv
// Bench for clk_div_monitor: two instances (7/4 and 3/1) share one clk_div stream.
// A sample-history model predicts every output on every cycle, plus a few fixed spot checks.
// Stimulus is cycle-level: clk_div changes just after each clk_in rising edge.
module tb_clk_div_monitor;

    localparam int CNT_W = 8;
    localparam int TMAX  = (1 << CNT_W) - 1;

    typedef struct packed {
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] hi;
        logic             mv;
        logic             err;
        logic             lk;
    } obs_t;

    logic             clk_in;
    logic             rst;
    logic             clk_div;
    logic [CNT_W-1:0] per_a, hi_a, per_b, hi_b;
    logic             mv_a, err_a, lk_a, mv_b, err_b, lk_b;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state per instance: 0 -> EXP_DIV=7/LOCK_N=4, 1 -> EXP_DIV=3/LOCK_N=1.
    int   exp_div [2] = '{7, 3};
    int   lock_n  [2] = '{4, 1};
    bit   m_meas  [2];
    int   m_rise  [2];
    int   m_mc    [2];
    bit   m_lk    [2];
    int   m_per   [2];
    int   m_hi    [2];
    obs_t d1      [2];
    obs_t d2      [2];
    obs_t exp_now [2];
    bit   samp    [$];

    clk_div_monitor #(.CNT_W(CNT_W), .EXP_DIV(7), .LOCK_N(4)) u_dut7 (
        .clk_in    (clk_in),
        .rst       (rst),
        .clk_div   (clk_div),
        .period    (per_a),
        .high_cnt  (hi_a),
        .meas_valid(mv_a),
        .err       (err_a),
        .locked    (lk_a)
    );

    clk_div_monitor #(.CNT_W(CNT_W), .EXP_DIV(3), .LOCK_N(1)) u_dut3 (
        .clk_in    (clk_in),
        .rst       (rst),
        .clk_div   (clk_div),
        .period    (per_b),
        .high_cnt  (hi_b),
        .meas_valid(mv_b),
        .err       (err_b),
        .locked    (lk_b)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic obs_t dut_obs(input int u);
        if (u == 0) return {per_a, hi_a, mv_a, err_a, lk_a};
        return {per_b, hi_b, mv_b, err_b, lk_b};
    endfunction

    task automatic model_reset();
        samp.delete();
        for (int u = 0; u < 2; u++) begin
            m_meas[u]  = 1'b0;
            m_rise[u]  = 0;
            m_mc[u]    = 0;
            m_lk[u]    = 1'b0;
            m_per[u]   = 0;
            m_hi[u]    = 0;
            d1[u]      = '0;
            d2[u]      = '0;
            exp_now[u] = '0;
        end
    endtask

    // Sample n of clk_div (taken at edge n after reset release) is reflected in outputs after edge n+2.
    task automatic model_step(input bit v);
        int   n;
        bit   is_rise;
        obs_t s;
        samp.push_back(v);
        n = samp.size() - 1;
        is_rise = v;
        if (n > 0 && samp[n-1]) is_rise = 1'b0;
        for (int u = 0; u < 2; u++) begin
            s = '0;
            if (!m_meas[u]) begin
                if (is_rise) begin
                    m_meas[u] = 1'b1;
                    m_rise[u] = n;
                end
            end else if (is_rise) begin
                m_per[u] = n - m_rise[u];
                m_hi[u]  = 0;
                for (int i = m_rise[u]; i < n; i++) begin
                    if (samp[i]) m_hi[u]++;
                end
                s.mv = 1'b1;
                if (m_per[u] == exp_div[u] &&
                    (m_hi[u] == exp_div[u] / 2 || m_hi[u] == exp_div[u] / 2 + 1)) begin
                    if (m_mc[u] < lock_n[u]) m_mc[u]++;
                    if (m_mc[u] == lock_n[u]) m_lk[u] = 1'b1;
                end else begin
                    m_mc[u] = 0;
                    m_lk[u] = 1'b0;
                    s.err   = 1'b1;
                end
                m_rise[u] = n;
            end else if (n - m_rise[u] == TMAX) begin
                s.err     = 1'b1;
                m_lk[u]   = 1'b0;
                m_mc[u]   = 0;
                m_meas[u] = 1'b0;
            end
            s.per = CNT_W'(m_per[u]);
            s.hi  = CNT_W'(m_hi[u]);
            s.lk  = m_lk[u];
            exp_now[u] = d2[u];
            d2[u] = d1[u];
            d1[u] = s;
        end
    endtask

    task automatic compare_all();
        obs_t o;
        for (int u = 0; u < 2; u++) begin
            o = dut_obs(u);
            check_eq($sformatf("u%0d.period", u),     o.per, exp_now[u].per);
            check_eq($sformatf("u%0d.high_cnt", u),   o.hi,  exp_now[u].hi);
            check_eq($sformatf("u%0d.meas_valid", u), o.mv,  exp_now[u].mv);
            check_eq($sformatf("u%0d.err", u),        o.err, exp_now[u].err);
            check_eq($sformatf("u%0d.locked", u),     o.lk,  exp_now[u].lk);
        end
    endtask

    task automatic check_idle(input string tag);
        obs_t o;
        for (int u = 0; u < 2; u++) begin
            o = dut_obs(u);
            check_eq($sformatf("%s.u%0d.outputs", tag, u), int'(o), 0);
        end
    endtask

    // Called just after a rising edge: drive the next sample, advance one cycle, compare.
    task automatic step(input bit v);
        clk_div = v;
        model_step(v);
        @(posedge clk_in);
        #1;
        compare_all();
    endtask

    task automatic gen_clk(input int div, input int hi, input int periods);
        int h;
        for (int p = 0; p < periods; p++) begin
            h = (hi > 0) ? hi : div / 2 + int'($urandom_range(0, 1));
            for (int i = 0; i < div; i++) step(i < h);
        end
    endtask

    task automatic hold(input bit v, input int cycles);
        for (int i = 0; i < cycles; i++) step(v);
    endtask

    initial begin
        int d;
        int sel;
        clk_div = 1'b0;
        rst     = 1'b0;
        model_reset();
        repeat (3) @(posedge clk_in);
        #1;
        check_idle("reset");
        rst = 1'b1;

        // Divide-by-7, 50% duty: lock on the 4th measurement.
        gen_clk(7, 0, 8);
        check_eq("t1.locked", lk_a, 1);
        check_eq("t1.period", per_a, 7);
        check_eq("t1.u3_locked", lk_b, 0);

        // Wrong ratio breaks lock, correct ratio restores it.
        gen_clk(5, 0, 3);
        check_eq("t2.unlocked", lk_a, 0);
        check_eq("t2.period", per_a, 5);
        gen_clk(7, 0, 6);
        check_eq("t2.relocked", lk_a, 1);

        // Right period, wrong duty.
        gen_clk(7, 1, 5);
        check_eq("t3.locked", lk_a, 0);
        check_eq("t3.high_cnt", hi_a, 1);
        check_eq("t3.period", per_a, 7);

        // Stopped low after lock: timeout, period held.
        gen_clk(7, 0, 5);
        check_eq("t4.pre_locked", lk_a, 1);
        hold(1'b0, 300);
        check_eq("t4.locked", lk_a, 0);
        check_eq("t4.period", per_a, 7);
        gen_clk(7, 0, 6);
        check_eq("t4.relocked", lk_a, 1);

        // Stuck high.
        hold(1'b1, 300);
        check_eq("t4b.locked", lk_a, 0);

        // Divide-by-3 instance locks on its first good measurement.
        hold(1'b0, 2);
        gen_clk(3, 0, 6);
        check_eq("t6.u3_locked", lk_b, 1);
        check_eq("t6.u3_period", per_b, 3);

        // Asynchronous reset in the middle of a period while locked.
        gen_clk(7, 0, 6);
        check_eq("t5.pre_locked", lk_a, 1);
        step(1'b1);
        step(1'b1);
        #2 rst = 1'b0;
        #1;
        check_idle("async_rst");
        repeat (2) @(posedge clk_in);
        #1;
        check_idle("rst_held");
        rst = 1'b1;
        model_reset();
        gen_clk(7, 0, 6);
        check_eq("t5.relocked", lk_a, 1);

        // Randomized mix of ratios, duties, stalls and near-timeout periods.
        for (int k = 0; k < 40; k++) begin
            sel = int'($urandom_range(0, 5));
            case (sel)
                0, 1: gen_clk(7, 0, int'($urandom_range(1, 6)));
                2:    gen_clk(3, 0, int'($urandom_range(1, 6)));
                3: begin
                    d = int'($urandom_range(2, 16));
                    gen_clk(d, int'($urandom_range(1, d - 1)), int'($urandom_range(1, 4)));
                end
                4: begin
                    d = int'($urandom_range(253, 258));
                    gen_clk(d, int'($urandom_range(1, d - 1)), int'($urandom_range(1, 2)));
                end
                default: hold(1'($urandom_range(0, 1)), int'($urandom_range(1, 300)));
            endcase
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/clk_div_monitor.md
Name: clk_div_monitor

Overview:
- Receive-side checker for odd-ratio divided clocks such as the divide-by-7, 50%-duty output of the team's odd dividers.
- Synchronizes the divided clock into the clk_in domain as plain data.
- Measures period and high time in clk_in cycles.
- Flags mismatches against the expected ratio, and declares lock after LOCK_N consecutive good periods.
- Used in self-check benches and in on-chip clock-health status.

Parameters:
- CNT_W, 8: width of period/high counters and outputs.
- EXP_DIV, 7: expected period in clk_in cycles (odd, 3..2^CNT_W-2).
- LOCK_N, 4: consecutive matching periods required for lock (1..15).

Ports:
- clk_in  input  1  reference clock; all logic on posedge.
- rst  input  1  asynchronous active-low reset.
- clk_div  input  1  divided clock under test, treated as async data.
- period  output  CNT_W  last measured period, rising edge to rising edge, in clk_in cycles.
- high_cnt  output  CNT_W  clk_in cycles with synced clk_div high in the last period.
- meas_valid  output  1  one-cycle pulse: period/high_cnt updated this cycle.
- err  output  1  one-cycle pulse: mismatch or timeout.
- locked  output  1  level: LOCK_N consecutive matches seen, no error since.

Behaviour:
- Interface: one clock; reset is asynchronous and active-low.
- Reset values: all outputs 0, counters 0, synchronizer flops 0, state IDLE.
- Synchronizer: s1 <= clk_div; s2 <= s1; s3 <= s2.
  - rise = s2 & ~s3, combinational.
  - Rise is detected 2–3 clk_in cycles after the clk_div edge.
- States:
  - IDLE: wait for rise. On rise: cnt_per <= 1, cnt_hi <= 1, go to MEAS. No meas_valid on this first rise.
  - MEAS, no rise: cnt_per increments every cycle; cnt_hi increments when s2 = 1.
  - MEAS, on rise:
    - period <= cnt_per, high_cnt <= cnt_hi, meas_valid <= 1 (registered, so it is seen the cycle after rise).
    - cnt_per <= 1, cnt_hi <= 1.
- Match rule: period == EXP_DIV and high_cnt ∈ {EXP_DIV/2, EXP_DIV/2+1} (integer division; for 7 this is {3,4}).
  - Evaluated on the rise cycle using the cnt values being latched.
- Match counter (4-bit):
  - On match: increments, saturating at LOCK_N.
  - locked <= 1 on the same cycle meas_valid asserts with the count reaching LOCK_N.
- On mismatch: match count <= 0, locked <= 0, err <= 1, all on the same cycle as meas_valid. Stay in MEAS.
- Timeout: in MEAS, when cnt_per == 2^CNT_W-1 and no rise:
  - err <= 1 for one cycle, locked <= 0, match count <= 0, go to IDLE.
  - No meas_valid; period/high_cnt hold their old values.
- Counters never wrap, because timeout fires first.
- meas_valid and err are single-cycle pulses; both deassert the next cycle unless re-triggered.
- Reset mid-measurement: immediate clear to reset values. The first rise after release is treated as a first rise (no measurement).
- clk_div stuck high: no rise occurs, so timeout as above.
- Outputs are all registered; none depends combinationally on clk_div.

Test Plan:
1. Feed a divide-by-7 50%-duty clock (OR of pos/neg-edge halves) after reset release.
   - First rise: no pulse.
   - Then meas_valid every 7 cycles with period=7, high_cnt=3 or 4, err never asserting.
   - locked rises on the 4th meas_valid.
2. While locked, switch the stimulus to divide-by-5.
   - Next meas_valid: period=5, err pulse in the same cycle, locked=0.
   - After switching back to divide-by-7, locked returns on the 4th good period.
3. Divide-by-7 with 1-cycle-high duty.
   - period=7, high_cnt=1, err on each meas_valid, locked stays 0.
4. Hold clk_div low after lock.
   - 255 cycles after the last rise: err pulse, locked=0, period still 7, no meas_valid.
   - Resuming clock: first rise silent, then measurements resume.
5. Assert rst mid-period while locked.
   - All outputs 0 immediately (asynchronous).
   - After release, the first rise gives no meas_valid; the next gives period=7.
6. Parameter sweep EXP_DIV=3, LOCK_N=1 with a divide-by-3 stimulus.
   - period=3, high_cnt ∈ {1,2}, locked at the first meas_valid.
